// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared constants and state/owner encodings for the refill arbiter
package cpu_mem_pkg;
    localparam int BLOCK_BITS  = 256;
    localparam int OFFSET_BITS = 5;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/mem_refill_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker, bit 1 (D) wins a tie unless it went last
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       valid
);
    always_comb begin
        valid = |req;
        pick  = (req == 2'b11) ? ~last : req[1];
    end
endmodule

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one block-read memory port between I- and D-cache refills
module mem_refill_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MEM_LAT    = 9,
    parameter int BLOCK_BITS = cpu_mem_pkg::BLOCK_BITS,
    parameter int ADDR_BITS  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_req,
    input  logic [ADDR_BITS-1:0]  i_addr,
    output logic                  i_gnt,
    output logic                  i_done,
    input  logic                  d_req,
    input  logic [ADDR_BITS-1:0]  d_addr,
    output logic                  d_gnt,
    output logic                  d_done,
    output logic [BLOCK_BITS-1:0] blk_out,
    output logic                  mem_rd,
    output logic [ADDR_BITS-1:0]  mem_addr,
    input  logic [BLOCK_BITS-1:0] mem_block
);
    localparam logic [ADDR_BITS-1:0] OFS_MASK = ADDR_BITS'((1 << OFFSET_BITS) - 1);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d, last_q, last_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  mem_rd_q, mem_rd_d, i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
    logic                  i_done_q, i_done_d, d_done_q, d_done_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_BITS-1:0] blk_q, blk_d;
    logic                  pick, valid;

    rr_pick2 u_pick (
        .req   ({d_req, i_req}),
        .last  (last_q == OWN_D),
        .pick  (pick),
        .valid (valid)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        i_gnt_d    = i_gnt_q;
        d_gnt_d    = d_gnt_q;
        i_done_d   = 1'b0;
        d_done_d   = 1'b0;
        blk_d      = blk_q;
        case (state_q)
            IDLE: if (valid) begin
                owner_d    = pick ? OWN_D : OWN_I;
                mem_addr_d = (pick ? d_addr : i_addr) & ~OFS_MASK;
                mem_rd_d   = 1'b1;
                i_gnt_d    = ~pick;
                d_gnt_d    = pick;
                cnt_d      = 4'(MEM_LAT - 1);
                state_d    = BUSY;
            end
            BUSY: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                blk_d    = mem_block;
                mem_rd_d = 1'b0;
                i_gnt_d  = 1'b0;
                d_gnt_d  = 1'b0;
                i_done_d = (owner_q == OWN_I);
                d_done_d = (owner_q == OWN_D);
                last_d   = owner_q;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            owner_q    <= OWN_I;
            last_q     <= OWN_I;
            cnt_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            blk_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_done_q   <= i_done_d;
            d_done_q   <= d_done_d;
            blk_q      <= blk_d;
        end
    end

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign blk_out  = blk_q;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: directed checks of grant order, latency, capture and reset abort
module tb_mem_refill_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_req, d_req, i_req1;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] mem_block;
    logic         i_gnt, d_gnt, i_done, d_done, mem_rd;
    logic [31:0]  mem_addr;
    logic [255:0] blk_out;
    logic         u1_i_gnt, u1_d_gnt, u1_i_done, u1_d_done, u1_mem_rd;
    logic [31:0]  u1_mem_addr;
    logic [255:0] u1_blk_out;

    int          passed = 0, total = 0, ng = 0, n = 0;
    int          gcyc[4];
    logic        gown[4];
    logic [31:0] gaddr[4];
    logic        both, seen;

    localparam logic [255:0] A = {8{32'h1111_1111}};
    localparam logic [255:0] B = {8{32'hCAFE_F00D}};
    localparam logic [255:0] C = {4{64'h0123_4567_89AB_CDEF}};

    always #5 clk = ~clk;

    mem_refill_arbiter #(.MEM_LAT(9)) u9 (
        .CLK(clk), .RESET(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_done(d_done),
        .blk_out(blk_out), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_block(mem_block)
    );

    mem_refill_arbiter #(.MEM_LAT(1)) u1 (
        .CLK(clk), .RESET(rst_n),
        .i_req(i_req1), .i_addr(i_addr), .i_gnt(u1_i_gnt), .i_done(u1_i_done),
        .d_req(1'b0), .d_addr(d_addr), .d_gnt(u1_d_gnt), .d_done(u1_d_done),
        .blk_out(u1_blk_out), .mem_rd(u1_mem_rd), .mem_addr(u1_mem_addr), .mem_block(mem_block)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic track(input int want);
        logic pi, pd;
        pi = 1'b0; pd = 1'b0; ng = 0; both = 1'b0;
        for (int c = 0; c < 80 && ng < want; c++) begin
            @(negedge clk);
            if ((i_gnt && d_gnt) || (i_done && d_done)) both = 1'b1;
            if ((i_gnt && !pi) || (d_gnt && !pd)) begin
                gcyc[ng] = c; gown[ng] = d_gnt; gaddr[ng] = mem_addr; ng++;
            end
            pi = i_gnt; pd = d_gnt;
        end
    endtask

    task automatic wait_done(input logic want_d);
        n = 0;
        while (!(want_d ? d_done : i_done) && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b1; i_req = 0; d_req = 0; i_req1 = 0;
        i_addr = '0; d_addr = '0; mem_block = A;
        #2 rst_n = 1'b0;
        step(2);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_gnt", {i_gnt, d_gnt}, 0);
        check("rst_done", {i_done, d_done}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_blk", blk_out, 0);
        rst_n = 1'b1;
        step(1);

        // single I refill, MEM_LAT=9
        i_req = 1; i_addr = 32'h0040_0A37;
        step(1);
        check("t1_gnt", {i_gnt, d_gnt}, 2'b10);
        check("t1_addr", mem_addr, 32'h0040_0A20);
        i_addr = 32'hFFFF_FFFF;
        n = 0;
        while (mem_rd && n < 20) begin
            n++;
            mem_block = (n == 9) ? B : A;
            step(1);
        end
        check("t1_rd_cycles", n, 9);
        check("t1_done", {i_done, d_done}, 2'b10);
        check("t1_blk", blk_out, B);
        check("t1_gnt_drop", {i_gnt, d_gnt}, 0);
        i_req = 0;
        mem_block = A;
        step(1);
        check("t1_done_pulse", i_done, 0);
        check("t1_blk_hold", blk_out, B);

        // tie after reset: D first, then strict alternation
        rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
        i_req = 1; d_req = 1; i_addr = 32'h1000_0011; d_addr = 32'h2000_0FFF;
        track(4);
        check("t2_ngrants", ng, 4);
        check("t2_exclusive", both, 0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("t2_owner%0d", j), gown[j], (j % 2 == 0));
            check($sformatf("t2_addr%0d", j), gaddr[j], (j % 2 == 0) ? 32'h2000_0FE0 : 32'h1000_0000);
            if (j > 0) check($sformatf("t2_space%0d", j), gcyc[j] - gcyc[j-1], 11);
        end
        i_req = 0; d_req = 0;
        wait_done(1'b0);
        check("t2_last_done", i_done, 1);
        step(2);

        // D arrives mid I transfer and must wait; its address is taken at grant
        i_req = 1; i_addr = 32'h0000_1234;
        step(3);
        d_req = 1; d_addr = 32'hAAAA_AA55;
        step(1);
        check("t3_d_waits", d_gnt, 0);
        check("t3_i_addr", mem_addr, 32'h0000_1220);
        d_addr = 32'hBBBB_BB7F;
        wait_done(1'b0);
        check("t3_i_done", i_done, 1);
        i_req = 0;
        step(2);
        check("t3_d_gnt", {i_gnt, d_gnt}, 2'b01);
        check("t3_d_addr", mem_addr, 32'hBBBB_BB60);
        wait_done(1'b1);
        check("t3_d_done", d_done, 1);
        check("t3_d_blk", blk_out, A);
        d_req = 0;
        step(2);

        // reset while BUSY with cnt=4 aborts the transfer
        i_req = 1; i_addr = 32'h0000_0040;
        step(1);
        check("t4_rd", mem_rd, 1);
        step(4);
        rst_n = 1'b0;
        #1;
        check("t4_abort_rd", mem_rd, 0);
        check("t4_abort_gnt", {i_gnt, d_gnt}, 0);
        check("t4_abort_addr", mem_addr, 0);
        check("t4_abort_blk", blk_out, 0);
        i_req = 0;
        step(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (i_done || d_done || mem_rd) seen = 1'b1;
        end
        check("t4_no_done", seen, 0);
        i_req = 1; i_addr = 32'hDEAD_BEEF; mem_block = C;
        step(1);
        check("t4_regrant_addr", mem_addr, 32'hDEAD_BEE0);
        wait_done(1'b0);
        check("t4_regrant_done", i_done, 1);
        check("t4_regrant_blk", blk_out, C);
        i_req = 0;
        step(2);

        // MEM_LAT=1 instance: one BUSY cycle, done at k+2
        i_req1 = 1;
        step(1);
        check("t5_rd", {u1_mem_rd, u1_i_gnt}, 2'b11);
        mem_block = B;
        step(1);
        check("t5_rd_off", u1_mem_rd, 0);
        check("t5_done", {u1_i_done, u1_d_done}, 2'b10);
        check("t5_blk", u1_blk_out, B);
        i_req1 = 0;
        step(2);

        // I held through done: back-to-back grants spaced MEM_LAT+2
        i_req = 1; i_addr = 32'h0000_0100;
        track(2);
        check("t6_ngrants", ng, 2);
        check("t6_owners", {gown[0], gown[1]}, 2'b00);
        check("t6_space", gcyc[1] - gcyc[0], 11);
        i_req = 0;
        wait_done(1'b0);
        check("t6_done", i_done, 1);
        step(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares the single block-read memory port between instruction-cache and data-cache refill requests.
- Grants one requester at a time and presents the block-aligned address to memory.
- Counts a fixed memory latency, captures the 256-bit block, and returns it with a one-cycle done pulse to the owner.
- Sits between both caches and main memory; replaces each cache driving the memory address directly.

Parameters:
- MEM_LAT, 9: memory read latency in cycles, from mem_rd assertion to a valid mem_block; legal range 1..15.
- BLOCK_BITS, 256: cache block width in bits (32 B).
- ADDR_BITS, 32: byte address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache refill request; level, held until i_done.
- i_addr  in  32  I-cache miss address.
- i_gnt  out  1  I-cache currently owns the memory port.
- i_done  out  1  one-cycle pulse: blk_out holds the I-cache block.
- d_req  in  1  D-cache refill request; level, held until d_done.
- d_addr  in  32  D-cache miss address.
- d_gnt  out  1  D-cache currently owns the memory port.
- d_done  out  1  one-cycle pulse: blk_out holds the D-cache block.
- blk_out  out  256  captured block; held until the next capture.
- mem_rd  out  1  memory block-read strobe.
- mem_addr  out  32  block-aligned memory address.
- mem_block  in  256  memory read data; valid in the final wait cycle.

Behaviour:
- Reset: state=IDLE; mem_rd, i_gnt, d_gnt, i_done, d_done=0; mem_addr=0; blk_out=0; cnt=0; last=I, so D wins the first tie.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - If no request is asserted, stay in IDLE; all strobes are 0.
  - If exactly one request is asserted, grant it.
  - If both are asserted, grant the requester that is not `last` (round-robin).
  - On grant: latch owner; mem_addr <= {addr[31:5],5'b0}; mem_rd<=1; owner gnt<=1; cnt<=MEM_LAT-1; go to BUSY.
- BUSY:
  - mem_rd, mem_addr and gnt are held stable.
  - Requester addresses and the non-owner's req are ignored.
  - If cnt!=0, decrement cnt.
  - If cnt==0: blk_out<=mem_block; mem_rd<=0; gnt<=0; owner done<=1; last<=owner; go to DONE.
- DONE:
  - done<=0; go to IDLE. No grant is issued in this cycle.
- Timing: request sampled at edge k → mem_rd high during cycles k+1..k+MEM_LAT → done high in cycle k+MEM_LAT+1.
- Minimum spacing between grants is MEM_LAT+2 cycles.
- Requesters deassert req in the cycle after done. A req still high when IDLE is re-entered is treated as a new request.
- Starvation: with both reqs held continuously, grants alternate I/D strictly.
- i_done and d_done are never high together. i_gnt and d_gnt are never high together.
- Reset mid-operation: the transfer aborts immediately. No done pulse is produced, blk_out clears, and the requester must re-request.
- Address bits [4:0] never reach mem_addr.
- Counter width: 4 bits, compared for ==0. MEM_LAT=1 gives exactly one BUSY cycle.

Decomposition:
- Package cpu_mem_pkg holds:
  - BLOCK_BITS=256 and OFFSET_BITS=5;
  - state enum {IDLE,BUSY,DONE};
  - owner enum {OWN_I,OWN_D}.
- One sub-module, rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0] and last.
  - Outputs: pick and valid.
- The FSM, counter and capture registers stay in mem_refill_arbiter.

Test Plan:
- Reset, then i_req=1 with i_addr=0x0040_0A37, MEM_LAT=9 → mem_addr=0x0040_0A20, mem_rd high for 9 cycles; i_done pulses with blk_out equal to the mem_block value in the last BUSY cycle.
- i_req and d_req both rise in the same cycle after reset → D granted first; I granted MEM_LAT+2 cycles after D's grant; grants alternate D,I,D,I for 4 transfers.
- d_req rises 3 cycles into an I transfer → D waits; d_addr changes during the wait; D's mem_addr reflects d_addr at grant time.
- RESET asserted at BUSY cnt=4 → next cycle all outputs are 0; no done pulse; a fresh i_req after release completes normally.
- MEM_LAT=1 build: single request → mem_rd high exactly 1 cycle, done in cycle k+2.
- i_req held high through i_done → a second I transfer starts after DONE; with no other requester, grant spacing is exactly MEM_LAT+2.
